// File: rtl/debug_responder_if.sv
// Debug register bus between debug_controller (master) and debug_responder (slave).
// dbg_req is a level held until dbg_ack; dbg_dout is valid while dbg_ack=1.
interface debug_responder_if;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_din;
    logic [31:0] dbg_dout;
    logic        dbg_wr_en;
    logic        dbg_req;
    logic        dbg_ack;

    modport master (
        output dbg_addr, dbg_din, dbg_wr_en, dbg_req,
        input  dbg_dout, dbg_ack
    );

    modport slave (
        input  dbg_addr, dbg_din, dbg_wr_en, dbg_req,
        output dbg_dout, dbg_ack
    );
endinterface

// File: rtl/debug_responder.sv
// SoC-side target of the debug register bus: CMD/ADDR/DATA/STATUS registers and a
// single-outstanding command launch to the CPU debug port, with optional timeout.
module debug_responder #(
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    debug_responder_if.slave     bus,
    output logic                 cmd_valid,
    output logic [CMD_WIDTH-1:0] cmd,
    output logic [31:0]          cmd_addr,
    output logic [31:0]          cmd_wdata,
    input  logic                 cmd_done,
    input  logic [31:0]          cmd_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_EXEC,
        S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          dout_q, dout_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_hit;

    // Counter already shows TIMEOUT-1 elapsed cycles: this edge is the TIMEOUT-th.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.dbg_req) begin
                    state_d = S_ACK;
                    if (bus.dbg_wr_en) begin
                        unique case (bus.dbg_addr)
                            2'd0: cmd_d  = bus.dbg_din[CMD_WIDTH-1:0];
                            2'd1: addr_d = bus.dbg_din;
                            2'd2: data_d = bus.dbg_din;
                            2'd3: begin
                                state_d = S_EXEC;
                                cnt_d   = '0;
                            end
                        endcase
                    end else begin
                        unique case (bus.dbg_addr)
                            2'd0: dout_d = 32'(cmd_q);
                            2'd1: dout_d = addr_q;
                            2'd2: dout_d = data_q;
                            2'd3: begin
                                dout_d = {31'b0, err_q};
                                err_d  = 1'b0;
                            end
                        endcase
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cmd_done) begin
                    data_d  = cmd_rdata;
                    state_d = S_ACK;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.dbg_req) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from the state register so reset drops them at once.
    assign bus.dbg_ack  = (state_q == S_ACK);
    assign bus.dbg_dout = dout_q;
    assign cmd_valid    = (state_q == S_EXEC);
    assign cmd          = cmd_q;
    assign cmd_addr     = addr_q;
    assign cmd_wdata    = data_q;

endmodule

// File: tb/tb_debug_responder.sv
// Randomized bench for debug_responder: transaction-level register model plus a
// CPU model that answers each launched command after a chosen delay (or never).
module tb_debug_responder;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [CW-1:0] cmd;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          cmd_done;
    logic [31:0]   cmd_rdata;

    debug_responder_if bus_if ();

    debug_responder #(
        .CMD_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_done  (cmd_done),
        .cmd_rdata (cmd_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register-level reference state
    logic [31:0] m_cmd, m_addr, m_data, m_last;
    logic        m_err;

    int          cpu_delay;   // 0 = CPU never answers
    logic [31:0] cpu_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // CPU model: pulse cmd_done on the cpu_delay-th cycle of cmd_valid; stray
    // done pulses while idle must be ignored by the responder.
    initial begin
        int k;
        k = 0;
        cmd_done  = 1'b0;
        cmd_rdata = '0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            if (cmd_valid === 1'b1) begin
                k++;
                if (cpu_delay != 0 && k == cpu_delay) begin
                    cmd_done  = 1'b1;
                    cmd_rdata = cpu_rdata;
                end
            end else begin
                k = 0;
                if ($urandom_range(0, 3) == 0) begin
                    cmd_done  = 1'b1;
                    cmd_rdata = $urandom;
                end
            end
        end
    end

    task automatic access(input logic [1:0] a, input logic w, input logic [31:0] d, input int hold,
                          output logic [31:0] rd, output int acks, output int vcyc);
        bit got, seen;
        got  = 0;
        seen = 0;
        acks = 0;
        vcyc = 0;
        rd   = '0;
        @(negedge clk);
        bus_if.dbg_addr  = a;
        bus_if.dbg_wr_en = w;
        bus_if.dbg_din   = d;
        bus_if.dbg_req   = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                vcyc++;
                if (!seen) begin
                    seen = 1;
                    check_val("cmd_out", 32'(cmd), m_cmd);
                    check_val("cmd_addr_out", cmd_addr, m_addr);
                    check_val("cmd_wdata_out", cmd_wdata, m_data);
                end
            end
            if (bus_if.dbg_ack === 1'b1) begin
                acks++;
                got = 1;
                rd  = bus_if.dbg_dout;
            end
        end
        if (!got) check_val("ack_wait", 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus_if.dbg_ack === 1'b1) acks++;
            if (cmd_valid === 1'b1) vcyc++;
        end
        bus_if.dbg_req = 1'b0;
        @(negedge clk);
        if (bus_if.dbg_ack === 1'b1) acks++;
        if (cmd_valid === 1'b1) vcyc++;
    endtask

    task automatic do_op(input logic [1:0] a, input logic w, input logic [31:0] d,
                         input int delay, input logic [31:0] rdata, input int hold);
        logic [31:0] rd, exp;
        int acks, vcyc;
        cpu_delay = delay;
        cpu_rdata = rdata;
        case (a)
            2'd0:    exp = m_cmd;
            2'd1:    exp = m_addr;
            2'd2:    exp = m_data;
            default: exp = {31'b0, m_err};
        endcase
        access(a, w, d, hold, rd, acks, vcyc);
        check_val("ack_count", 32'(acks), 32'd1);
        if (!w) begin
            check_val($sformatf("read_reg%0d", a), rd, exp);
            m_last = exp;
            if (a == 2'd3) m_err = 1'b0;
        end else begin
            check_val("dout_hold", bus_if.dbg_dout, m_last);
            case (a)
                2'd0: begin m_cmd  = 32'(d[CW-1:0]); check_val("no_exec", 32'(vcyc), 32'd0); end
                2'd1: begin m_addr = d;              check_val("no_exec", 32'(vcyc), 32'd0); end
                2'd2: begin m_data = d;              check_val("no_exec", 32'(vcyc), 32'd0); end
                default: begin
                    if (delay != 0 && delay <= int'(TO)) begin
                        check_val("exec_valid_cycles", 32'(vcyc), 32'(delay));
                        m_data = rdata;
                    end else begin
                        check_val("timeout_valid_cycles", 32'(vcyc), 32'(TO));
                        m_err = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic model_reset();
        m_cmd  = '0;
        m_addr = '0;
        m_data = '0;
        m_last = '0;
        m_err  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus_if.dbg_addr  = '0;
        bus_if.dbg_din   = '0;
        bus_if.dbg_wr_en = 1'b0;
        bus_if.dbg_req   = 1'b0;
        cpu_delay        = 0;
        cpu_rdata        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ack", 32'(bus_if.dbg_ack), 32'd0);
        check_val("rst_dout", bus_if.dbg_dout, 32'd0);
        check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_val("rst_cmd", 32'(cmd), 32'd0);
        check_val("rst_cmd_addr", cmd_addr, 32'd0);
        check_val("rst_cmd_wdata", cmd_wdata, 32'd0);

        // Directed scenarios
        do_op(2'd1, 1'b1, 32'hDEADBEEF, 0, 32'h0, 0);
        do_op(2'd1, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd0, 1'b1, 32'h3, 0, 32'h0, 0);
        do_op(2'd3, 1'b1, 32'hFFFF_FFFF, 5, 32'h12345678, 0);
        do_op(2'd2, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b1, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b1, 32'h0, TO, 32'hCAFEF00D, 0);
        do_op(2'd3, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b1, 32'h0, 3, 32'hA5A5A5A5, 10);
        do_op(2'd0, 1'b1, 32'hFF, 0, 32'h0, 0);
        do_op(2'd0, 1'b0, 32'h0, 0, 32'h0, 0);

        // Reset in the middle of a command
        do_op(2'd2, 1'b1, 32'h55AA55AA, 0, 32'h0, 0);
        do_op(2'd2, 1'b0, 32'h0, 0, 32'h0, 0);
        cpu_delay = 0;
        @(negedge clk);
        bus_if.dbg_addr  = 2'd3;
        bus_if.dbg_wr_en = 1'b1;
        bus_if.dbg_req   = 1'b1;
        repeat (4) @(negedge clk);
        check_val("mid_exec_valid", 32'(cmd_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_valid", 32'(cmd_valid), 32'd0);
        check_val("async_rst_ack", 32'(bus_if.dbg_ack), 32'd0);
        check_val("async_rst_dout", bus_if.dbg_dout, 32'd0);
        bus_if.dbg_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_op(2'd0, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd1, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd2, 1'b0, 32'h0, 0, 32'h0, 0);
        do_op(2'd3, 1'b0, 32'h0, 0, 32'h0, 0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [1:0] a;
            logic       w;
            a = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            do_op(a, w, $urandom, $urandom_range(0, 20), $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
